l2_cache_control: RTL

Control FSM for the 4-way set-associative L2 cache. It sits between the L1 miss path and the physical-memory cacheline adaptor. It decides hit or miss from the datapath's way-hit vector and chooses the victim from the LRU queue's `lru_index`. It sequences dirty writeback and line fill, then drives the LRU queue's `load`/`mru` update on every completed access. It also keeps saturating hit, miss and writeback performance counters.

---
 rtl/l2_cache_types.sv | 27 ++
 rtl/l2_sat_counter.sv | 27 ++
 rtl/l2_cache_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/l2_cache_types.sv
// Purpose: shared types and constants for the L2 cache controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: l2_state_t controller states, way count/index width, and the
// encodings of the data-source and pmem-address muxes in the datapath.
package l2_cache_types;

  localparam int L2_WAYS  = 4;
  localparam int L2_WAY_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } l2_state_t;

  // data_src mux: which line is written into the data array
  localparam logic DATA_SRC_L1   = 1'b0;
  localparam logic DATA_SRC_PMEM = 1'b1;

  // pmem_addr_sel mux: which address is presented to physical memory
  localparam logic PMEM_ADDR_REQ    = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/l2_sat_counter.sv
// Purpose: saturating event counter; holds at all-ones instead of wrapping.
// Latency: count reflects an inc pulse on the next rising edge.
// Backpressure: none; one increment per cycle at most.
//
// Ports: clk, rst (sync, active-high), inc (count this cycle),
//        count [CNT_W-1:0] (current value).
module l2_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// Purpose: 4-way L2 control FSM: hit/miss decision, dirty writeback, line fill, LRU update, perf counters.
// Latency: hit responds 1 cycle after the request is sampled; misses add writeback/fill pmem transactions.
// Backpressure: L1 holds its request until l2_resp; pmem requests are level-held until pmem_resp.
//
// Ports: clk, rst (sync, active-high); L1 side l2_read/l2_write/l2_resp;
//        datapath side hit_vec, victim_valid/victim_dirty, way_sel, data_we,
//        data_src, tag_load, valid_set, dirty_set, dirty_clr, victim_way;
//        LRU queue lru_index/lru_load/mru; memory side pmem_addr_sel,
//        pmem_read, pmem_write, pmem_resp; counters hit/miss/wb_count.
module l2_cache_control
  import l2_cache_types::*;
#(
  parameter int WAYS  = 4,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                l2_read,
  input  logic                l2_write,
  output logic                l2_resp,
  input  logic [WAYS-1:0]     hit_vec,
  input  logic                victim_valid,
  input  logic                victim_dirty,
  input  logic [L2_WAY_W-1:0] lru_index,
  output logic                lru_load,
  output logic [L2_WAY_W-1:0] mru,
  output logic [L2_WAY_W-1:0] victim_way,
  output logic [L2_WAY_W-1:0] way_sel,
  output logic                data_we,
  output logic                data_src,
  output logic                tag_load,
  output logic                valid_set,
  output logic                dirty_set,
  output logic                dirty_clr,
  output logic                pmem_addr_sel,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output logic [CNT_W-1:0]    wb_count
);

  if (WAYS != L2_WAYS) begin : g_bad_ways
    $error("l2_cache_control: WAYS must be 4 to match the 2-bit LRU index");
  end

  // Lowest set bit wins if the datapath ever reports more than one hit.
  function automatic logic [L2_WAY_W-1:0] hit_index(input logic [L2_WAYS-1:0] v);
    hit_index = '0;
    for (int i = L2_WAYS - 1; i >= 0; i--) begin
      if (v[i]) hit_index = i[L2_WAY_W-1:0];
    end
  endfunction

  l2_state_t             state, state_d;
  logic [L2_WAY_W-1:0]   victim_q, victim_d;
  logic                  hit;
  logic                  hit_inc, miss_inc, wb_inc;

  assign hit = |hit_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      state    <= state_d;
      victim_q <= victim_d;
    end
  end

  // In COMPARE the victim is not latched yet, but the datapath must already
  // report valid/dirty for the LRU way so the writeback decision can be made
  // this cycle; so the LRU index is forwarded straight through.
  assign victim_way = (state == COMPARE) ? lru_index : victim_q;

  always_comb begin
    state_d       = state;
    victim_d      = victim_q;
    l2_resp       = 1'b0;
    lru_load      = 1'b0;
    mru           = '0;
    way_sel       = '0;
    data_we       = 1'b0;
    data_src      = DATA_SRC_L1;
    tag_load      = 1'b0;
    valid_set     = 1'b0;
    dirty_set     = 1'b0;
    dirty_clr     = 1'b0;
    pmem_addr_sel = PMEM_ADDR_REQ;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;

    unique case (state)
      IDLE: begin
        if (l2_read || l2_write) state_d = COMPARE;
      end

      COMPARE: begin
        if (hit) begin
          way_sel  = hit_index(hit_vec);
          lru_load = 1'b1;
          mru      = hit_index(hit_vec);
          l2_resp  = 1'b1;
          hit_inc  = 1'b1;
          if (l2_write) begin
            data_we   = 1'b1;
            data_src  = DATA_SRC_L1;
            dirty_set = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d = lru_index;
          miss_inc = 1'b1;
          state_d  = (victim_valid && victim_dirty) ? WRITEBACK : FETCH;
        end
      end

      WRITEBACK: begin
        way_sel       = victim_q;
        pmem_addr_sel = PMEM_ADDR_VICTIM;
        pmem_write    = 1'b1;
        if (pmem_resp) begin
          dirty_clr = 1'b1;
          wb_inc    = 1'b1;
          state_d   = FETCH;
        end
      end

      FETCH: begin
        way_sel       = victim_q;
        pmem_addr_sel = PMEM_ADDR_REQ;
        pmem_read     = 1'b1;
        if (pmem_resp) begin
          data_we   = 1'b1;
          data_src  = DATA_SRC_PMEM;
          tag_load  = 1'b1;
          valid_set = 1'b1;
          dirty_clr = 1'b1;
          // The filled way hits on re-compare, so response and LRU update
          // always come from the hit path.
          state_d   = COMPARE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  l2_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  l2_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  l2_sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );

  a_hit_onehot: assert property (@(posedge clk) disable iff (rst)
    (state == COMPARE) |-> $onehot0(hit_vec))
    else $error("l2_cache_control: multiple ways hit in COMPARE");

endmodule
